// File: rtl/gpu_op_executor.sv
// Consumer end of the GPU op FIFO: rasterises rectangle fills and upscaled 1-bpp sprite blits
// into the back framebuffer at one pixel per enabled cycle.
module gpu_op_executor #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned ASSET_ADDR_WIDTH  = 12,
    parameter int unsigned FB_ADDR_WIDTH     = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce_i,
    // {x, y, width, height, color, mem_en, mem_addr, scale}, MSB first
    input  logic [47+ASSET_ADDR_WIDTH:0]  op_i,
    output logic                          op_rd_en_o,
    input  logic                          op_empty_i,
    output logic [ASSET_ADDR_WIDTH-1:0]   asset_addr_o,
    input  logic                          asset_data_i,
    output logic                          fb_wr_en_o,
    output logic [FB_ADDR_WIDTH-1:0]      fb_addr_o,
    output logic                          fb_data_o,
    output logic                          busy_o
);

    typedef struct packed {
        logic [10:0]                 x;
        logic [10:0]                 y;
        logic [10:0]                 width;
        logic [10:0]                 height;
        logic                        color;
        logic                        mem_en;
        logic [ASSET_ADDR_WIDTH-1:0] mem_addr;
        logic [1:0]                  scale;
    } gpu_op_t;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLatch = 2'd1;
    localparam logic [1:0] StDraw  = 2'd2;
    localparam logic [1:0] StFlush = 2'd3;

    localparam logic [11:0] HorLimit = 12'(HOR_ACTIVE_PIXELS);
    localparam logic [11:0] VerLimit = 12'(VER_ACTIVE_PIXELS);

    gpu_op_t op_in;
    assign op_in = gpu_op_t'(op_i);

    logic [1:0]                  state_q, state_d;
    logic                        busy_q, busy_d;
    gpu_op_t                     op_q, op_d;
    logic [10:0]                 col_q, col_d;
    logic [10:0]                 row_q, row_d;
    logic [11:0]                 xc_q, xc_d;
    logic [11:0]                 yr_q, yr_d;
    logic [FB_ADDR_WIDTH-1:0]    fb_row_q, fb_row_d;
    logic [ASSET_ADDR_WIDTH-1:0] arow_q, arow_d;
    logic                        pix_we_q, pix_we_d;
    logic                        pix_blit_q, pix_blit_d;
    logic                        pix_color_q, pix_color_d;
    logic [FB_ADDR_WIDTH-1:0]    fb_addr_q, fb_addr_d;

    logic        pop;
    logic        last_col;
    logic        last_row;
    logic        in_bounds;
    logic [10:0] row_inc;
    logic [10:0] scale_mask;
    logic [10:0] sprite_w;

    // Pop is combinational so the FIFO data lands exactly in the LATCH cycle.
    assign pop = ce_i && !rst && !op_empty_i && ((state_q == StIdle) || (state_q == StFlush));

    assign last_col   = (col_q == op_q.width - 11'd1);
    assign last_row   = (row_q == op_q.height - 11'd1);
    assign in_bounds  = (xc_q < HorLimit) && (yr_q < VerLimit);
    assign row_inc    = row_q + 11'd1;
    assign scale_mask = (11'd1 << op_q.scale) - 11'd1;
    assign sprite_w   = op_q.width >> op_q.scale;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        op_d        = op_q;
        col_d       = col_q;
        row_d       = row_q;
        xc_d        = xc_q;
        yr_d        = yr_q;
        fb_row_d    = fb_row_q;
        arow_d      = arow_q;
        pix_we_d    = 1'b0;
        pix_blit_d  = pix_blit_q;
        pix_color_d = pix_color_q;
        fb_addr_d   = fb_addr_q;

        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StLatch;
                    busy_d  = 1'b1;
                end
            end
            StLatch: begin
                op_d     = op_in;
                col_d    = '0;
                row_d    = '0;
                xc_d     = {1'b0, op_in.x};
                yr_d     = {1'b0, op_in.y};
                fb_row_d = FB_ADDR_WIDTH'(op_in.y * HOR_ACTIVE_PIXELS);
                arow_d   = '0;
                if ((op_in.width == 11'd0) || (op_in.height == 11'd0)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                pix_we_d    = in_bounds;
                pix_blit_d  = op_q.mem_en;
                pix_color_d = op_q.color;
                fb_addr_d   = fb_row_q + FB_ADDR_WIDTH'(xc_q);
                if (last_col) begin
                    col_d = '0;
                    xc_d  = {1'b0, op_q.x};
                    if (last_row) begin
                        state_d = StFlush;
                    end else begin
                        row_d    = row_inc;
                        yr_d     = yr_q + 12'd1;
                        fb_row_d = fb_row_q + FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
                        // Step to the next sprite row once every 2**scale screen rows.
                        if ((row_inc & scale_mask) == 11'd0) begin
                            arow_d = arow_q + ASSET_ADDR_WIDTH'(sprite_w);
                        end
                    end
                end else begin
                    col_d = col_q + 11'd1;
                    xc_d  = xc_q + 12'd1;
                end
            end
            StFlush: begin
                if (pop) begin
                    state_d = StLatch;
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            op_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            xc_q        <= '0;
            yr_q        <= '0;
            fb_row_q    <= '0;
            arow_q      <= '0;
            pix_we_q    <= 1'b0;
            pix_blit_q  <= 1'b0;
            pix_color_q <= 1'b0;
            fb_addr_q   <= '0;
        end else if (ce_i) begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            op_q        <= op_d;
            col_q       <= col_d;
            row_q       <= row_d;
            xc_q        <= xc_d;
            yr_q        <= yr_d;
            fb_row_q    <= fb_row_d;
            arow_q      <= arow_d;
            pix_we_q    <= pix_we_d;
            pix_blit_q  <= pix_blit_d;
            pix_color_q <= pix_color_d;
            fb_addr_q   <= fb_addr_d;
        end
    end

    // Asset address is driven from the issue-cycle counters; the ROM answers one cycle later,
    // which is when the registered pixel for that address is presented.
    assign asset_addr_o = op_q.mem_addr + arow_q + ASSET_ADDR_WIDTH'(col_q >> op_q.scale);
    assign op_rd_en_o   = pop;
    assign fb_wr_en_o   = pix_we_q;
    assign fb_addr_o    = fb_addr_q;
    assign fb_data_o    = pix_we_q & (pix_blit_q ? asset_data_i : pix_color_q);
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_gpu_op_executor.sv
// Directed bench for gpu_op_executor: FIFO and asset ROM models, framebuffer write scoreboard.
`define CHECK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed %0d expected %0d", tag, (obs), (exp)); \
        end \
    end

module tb_gpu_op_executor;
    localparam int HOR = 640;
    localparam int VER = 480;
    localparam int AW  = 12;
    localparam int FBW = 19;
    localparam int OPW = 48 + AW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ce  = 1'b1;
    logic [OPW-1:0] op  = '0;
    logic           op_rd_en;
    logic           op_empty;
    logic [AW-1:0]  asset_addr;
    logic           asset_data = 1'b0;
    logic           fb_wr_en;
    logic [FBW-1:0] fb_addr;
    logic           fb_data;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic           rom    [0:4095];
    logic           fb_mem [0:HOR*VER-1];
    logic [OPW-1:0] fifo   [0:15];
    int             wr_ptr = 0;
    int             rd_ptr = 0;
    logic [FBW:0]   exp_q  [$];
    int             aa_log [0:16383];
    int             nwr = 0;
    int             mism = 0;
    int             rd_while_empty = 0;
    int             prev_aa = 0;

    always #5 clk = ~clk;

    gpu_op_executor dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce),
        .op_i         (op),
        .op_rd_en_o   (op_rd_en),
        .op_empty_i   (op_empty),
        .asset_addr_o (asset_addr),
        .asset_data_i (asset_data),
        .fb_wr_en_o   (fb_wr_en),
        .fb_addr_o    (fb_addr),
        .fb_data_o    (fb_data),
        .busy_o       (busy)
    );

    assign op_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (ce) asset_data <= rom[asset_addr];
        if (ce && op_rd_en) begin
            op     <= fifo[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Outputs are stable at the falling edge; a write commits when ce is high.
    always @(negedge clk) begin
        if (!rst && ce) begin
            if (op_rd_en && op_empty) rd_while_empty++;
            if (fb_wr_en) begin
                if (exp_q.size() == 0) mism++;
                else if (exp_q.pop_front() !== {fb_addr, fb_data}) mism++;
                fb_mem[fb_addr] = fb_data;
                aa_log[nwr & 16383] = prev_aa;
                nwr++;
            end
            prev_aa = int'(asset_addr);
        end
    end

    task automatic push_op(input int x, input int y, input int w, input int h, input int color,
                           input int mem_en, input int maddr, input int s, output int n);
        int xa, ya, d;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                xa = x + c;
                ya = y + r;
                if (xa < HOR && ya < VER) begin
                    d = mem_en != 0 ? int'(rom[(maddr + (r >> s) * (w >> s) + (c >> s)) % 4096])
                                    : color;
                    exp_q.push_back({FBW'(ya * HOR + xa), 1'(d)});
                    n++;
                end
            end
        end
        fifo[wr_ptr] = {11'(x), 11'(y), 11'(w), 11'(h), 1'(color), 1'(mem_en), 12'(maddr), 2'(s)};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget, input bit randce, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            ce = randce ? 1'($urandom_range(0, 1)) : 1'b1;
            if (op_empty && !busy && !fb_wr_en && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        ce = 1'b1;
    endtask

    function automatic int aa_min(input int lo, input int hi);
        int m = 1 << 30;
        for (int i = lo; i < hi; i++) if (aa_log[i & 16383] < m) m = aa_log[i & 16383];
        return m;
    endfunction

    function automatic int aa_max(input int lo, input int hi);
        int m = -1;
        for (int i = lo; i < hi; i++) if (aa_log[i & 16383] > m) m = aa_log[i & 16383];
        return m;
    endfunction

    initial begin
        int  n, n1, n2, n3, base, rp;
        bit  ok, lastbusy;

        for (int i = 0; i < 4096; i++) rom[i] = 1'($urandom_range(0, 1));
        rom[0] = 1'b1;

        // Reset state
        step(3);
        `CHECK("rst_op_rd_en", op_rd_en, 1'b0)
        `CHECK("rst_fb_wr_en", fb_wr_en, 1'b0)
        `CHECK("rst_fb_data", fb_data, 1'b0)
        `CHECK("rst_busy", busy, 1'b0)
        `CHECK("rst_fb_addr", fb_addr, 19'd0)
        `CHECK("rst_asset_addr", asset_addr, 12'd0)
        rst = 1'b0;
        step(3);
        `CHECK("idle_empty_busy", busy, 1'b0)

        // Reset in the middle of a 40x72 fill
        push_op(0, 0, 40, 72, 1, 0, 0, 0, n);
        base = nwr;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (nwr - base >= 100) begin
                ok = 1'b1;
                break;
            end
        end
        `CHECK("midrst_reached_draw", ok, 1'b1)
        `CHECK("midrst_pre_mism", mism, 0)
        rst = 1'b1;
        #1;
        `CHECK("midrst_fb_wr_en", fb_wr_en, 1'b0)
        `CHECK("midrst_busy", busy, 1'b0)
        step(2);
        rst = 1'b0;
        exp_q.delete();
        base = nwr;
        step(200);
        `CHECK("midrst_no_writes_after", nwr - base, 0)
        `CHECK("midrst_busy_after", busy, 1'b0)

        // Fill with busy timing around the last write
        push_op(100, 300, 40, 72, 1, 0, 0, 0, n);
        base = nwr;
        ok = 1'b0;
        lastbusy = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (nwr - base == 2880) begin
                ok = 1'b1;
                break;
            end
            lastbusy = busy;
        end
        `CHECK("fill_done", ok, 1'b1)
        `CHECK("fill_count", nwr - base, 2880)
        `CHECK("fill_mism", mism, 0)
        `CHECK("fill_busy_at_last_write", lastbusy, 1'b1)
        `CHECK("fill_busy_low_after", busy, 1'b0)
        `CHECK("fill_px_139_371", fb_mem[371 * HOR + 139], 1'b1)

        // Blit 34x24 scale 1
        push_op(20, 100, 34, 24, 0, 1, 0, 1, n);
        base = nwr;
        wait_idle(3000, 1'b0, ok);
        `CHECK("blit_done", ok, 1'b1)
        `CHECK("blit_count", nwr - base, 816)
        `CHECK("blit_mism", mism, 0)
        `CHECK("blit_aa_min", aa_min(base, nwr), 0)
        `CHECK("blit_aa_max", aa_max(base, nwr), 203)
        `CHECK("blit_px_21_101", fb_mem[101 * HOR + 21], rom[0])

        // Digit glyph 40x72 scale 3
        push_op(400, 200, 40, 72, 0, 1, 519, 3, n);
        base = nwr;
        wait_idle(5000, 1'b0, ok);
        `CHECK("digit_done", ok, 1'b1)
        `CHECK("digit_count", nwr - base, 2880)
        `CHECK("digit_mism", mism, 0)
        `CHECK("digit_aa_min", aa_min(base, nwr), 519)
        `CHECK("digit_aa_max", aa_max(base, nwr), 563)

        // Right-edge and bottom-edge clipping
        push_op(620, 10, 40, 2, 1, 0, 0, 0, n);
        base = nwr;
        wait_idle(500, 1'b0, ok);
        `CHECK("clipx_done", ok, 1'b1)
        `CHECK("clipx_count", nwr - base, 40)
        `CHECK("clipx_mism", mism, 0)
        push_op(600, 479, 20, 3, 1, 0, 0, 0, n);
        base = nwr;
        wait_idle(500, 1'b0, ok);
        `CHECK("clipy_count", nwr - base, 20)
        `CHECK("clipy_mism", mism, 0)

        // Zero-sized ops are consumed without writes
        push_op(10, 10, 5, 0, 1, 0, 0, 0, n);
        push_op(10, 10, 0, 5, 1, 0, 0, 0, n);
        base = nwr;
        wait_idle(100, 1'b0, ok);
        `CHECK("zero_done", ok, 1'b1)
        `CHECK("zero_count", nwr - base, 0)
        `CHECK("zero_popped", rd_ptr, wr_ptr)

        // Three preloaded ops with random ce
        rp = rd_ptr;
        push_op(5, 5, 7, 3, 1, 0, 0, 0, n1);
        push_op(300, 200, 16, 8, 0, 1, 1000, 2, n2);
        push_op(630, 470, 20, 15, 1, 0, 0, 0, n3);
        base = nwr;
        wait_idle(6000, 1'b1, ok);
        `CHECK("flow_done", ok, 1'b1)
        `CHECK("flow_count", nwr - base, n1 + n2 + n3)
        `CHECK("flow_count_const", nwr - base, 249)
        `CHECK("flow_mism", mism, 0)
        `CHECK("flow_pops", rd_ptr - rp, 3)
        `CHECK("flow_rd_while_empty", rd_while_empty, 0)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
